// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined two-operand bitwise logic unit with valid/ready backpressure,
// registered result flags and a wrapping count of delivered results.
module logic_unit_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_ones,
  output logic [15:0]      o_count
);

  if (WIDTH == 0 || WIDTH > 64) begin : g_bad_width
    $error("logic_unit_pipe: WIDTH must be in 1..64");
  end
  if (STAGES == 0 || STAGES > 4) begin : g_bad_stages
    $error("logic_unit_pipe: STAGES must be in 1..4");
  end

  localparam int unsigned Last = STAGES - 1;

  typedef enum logic [2:0] {
    OpAnd  = 3'd0,
    OpOr   = 3'd1,
    OpXor  = 3'd2,
    OpNand = 3'd3,
    OpNor  = 3'd4,
    OpXnor = 3'd5,
    OpAndn = 3'd6,
    OpPass = 3'd7
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] alu_res;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q  [STAGES];
  logic [WIDTH-1:0]  data_d  [STAGES];
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] in_valid;
  logic [WIDTH-1:0]  in_data [STAGES];
  logic              zero_q, zero_d;
  logic              ones_q, ones_d;
  logic [15:0]       count_q, count_d;
  logic              deliver;

  assign op = op_e'(i_op);

  always_comb begin
    alu_res = i_a;
    unique case (op)
      OpAnd:  alu_res = i_a & i_b;
      OpOr:   alu_res = i_a | i_b;
      OpXor:  alu_res = i_a ^ i_b;
      OpNand: alu_res = ~(i_a & i_b);
      OpNor:  alu_res = ~(i_a | i_b);
      OpXnor: alu_res = ~(i_a ^ i_b);
      OpAndn: alu_res = i_a & ~i_b;
      OpPass: alu_res = i_a;
    endcase
  end

  // A stage may load if it is empty or anything downstream of it can drain this cycle,
  // so the ready chain ripples from the consumer back towards stage 0.
  always_comb begin : p_load
    logic nxt;
    load = '0;
    nxt  = i_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = ~valid_q[k] | nxt;
      nxt     = load[k];
    end
  end

  always_comb begin
    in_valid[0] = i_valid;
    in_data[0]  = alu_res;
    for (int k = 1; k < STAGES; k++) begin
      in_valid[k] = valid_q[k-1];
      in_data[k]  = data_q[k-1];
    end
  end

  assign deliver = valid_q[Last] & i_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    zero_d  = zero_q;
    ones_d  = ones_q;
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) begin
        valid_d[k] = in_valid[k];
        if (in_valid[k]) begin
          data_d[k] = in_data[k];
        end
      end
    end
    // Flags follow the data into the output stage so they never lag o_result.
    if (load[Last] && in_valid[Last]) begin
      zero_d = ~|in_data[Last];
      ones_d = &in_data[Last];
    end
    count_d = count_q + {15'd0, deliver};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
      zero_q  <= 1'b0;
      ones_q  <= 1'b0;
      count_q <= 16'd0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
      zero_q  <= zero_d;
      ones_q  <= ones_d;
      count_q <= count_d;
    end
  end

  assign o_ready  = load[0];
  assign o_valid  = valid_q[Last];
  assign o_result = data_q[Last];
  assign o_zero   = zero_q;
  assign o_ones   = ones_q;
  assign o_count  = count_q;

  property p_stall_stable;
    @(posedge i_clk) disable iff (!i_rst_n)
      (o_valid && !i_ready) |=>
        (o_valid && $stable(o_result) && $stable(o_zero) && $stable(o_ones));
  endproperty
  a_stall_stable: assert property (p_stall_stable);

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: negedge scoreboard plus per-scenario tasks.
module tb_logic_unit_pipe;
  localparam int unsigned W = 8;
  localparam int unsigned S = 2;

  localparam logic [7:0] OpsRes [8] = '{8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'h81, 8'hA5};
  localparam logic [7:0] TtA [4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
  localparam logic [7:0] TtB [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
  localparam logic [7:0] TtRes [4] = '{8'h00, 8'h00, 8'h00, 8'hFF};

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [2:0]   i_op = 3'd0;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic [W-1:0] o_result;
  logic         o_zero;
  logic         o_ones;
  logic [15:0]  o_count;

  logic_unit_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_zero   (o_zero),
    .o_ones   (o_ones),
    .o_count  (o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [7:0] res; logic zero; logic ones; int cyc; } exp_t;
  typedef struct { logic [7:0] res; logic zero; logic ones; int cyc; int lat; } got_t;

  exp_t        exp_q[$];
  got_t        got_q[$];
  exp_t        mon_e;
  got_t        mon_g;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc = 0;
  int          both_n = 0;
  logic [15:0] deliv_cnt = 16'd0;
  logic [7:0]  mres;

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  // Handshakes are decided by values that are stable at the falling edge.
  always @(negedge i_clk) begin
    cyc++;
    if (i_rst_n) begin
      if (o_valid && i_ready && i_valid && o_ready) both_n++;
      if (o_valid && i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow: delivered %h with nothing outstanding", o_result);
        end else begin
          mon_e = exp_q.pop_front();
          if (o_result !== mon_e.res || o_zero !== mon_e.zero || o_ones !== mon_e.ones) begin
            errors++;
            $display("FAIL scoreboard: got res=%h z=%b o=%b, expected res=%h z=%b o=%b",
                     o_result, o_zero, o_ones, mon_e.res, mon_e.zero, mon_e.ones);
          end
          mon_g.res = o_result; mon_g.zero = o_zero; mon_g.ones = o_ones;
          mon_g.cyc = cyc; mon_g.lat = cyc - mon_e.cyc;
          got_q.push_back(mon_g);
        end
        checks++;
        if (o_count !== deliv_cnt) begin
          errors++;
          $display("FAIL count_track: o_count=%h, expected %h", o_count, deliv_cnt);
        end
        deliv_cnt++;
      end
      if (i_valid && o_ready) begin
        mres = model(i_op, i_a, i_b);
        mon_e.res = mres; mon_e.zero = (mres == 8'h00); mon_e.ones = (mres == 8'hFF);
        mon_e.cyc = cyc;
        exp_q.push_back(mon_e);
        acc++;
      end
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_valid = 1'b0; i_ready = 1'b0; i_op = 3'd0; i_a = '0; i_b = '0;
    #2 i_rst_n = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    exp_q.delete(); got_q.delete(); acc = 0; both_n = 0; deliv_cnt = 16'd0;
    i_rst_n = 1'b1;
  endtask

  task automatic send(input logic [2:0] op_v, input logic [7:0] a_v, input logic [7:0] b_v);
    bit done = 1'b0;
    i_valid = 1'b1; i_op = op_v; i_a = a_v; i_b = b_v;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge i_clk);
      done = o_ready;
      @(posedge i_clk);
      #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: o_ready=%b, required 1 within 200 cycles", o_ready);
    end
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got_q.size() < n && t < 1000) begin
      @(negedge i_clk);
      #1;
      t++;
    end
    if (got_q.size() < n) begin
      checks++; errors++;
      $display("FAIL deliver_timeout: got %0d results, required %0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset;
    i_valid = 1'b0; i_ready = 1'b0;
    #2 i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    checks += 6;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", o_valid); end
    if (o_result !== 8'h00) begin errors++; $display("FAIL rst_result: got %h, required 00", o_result); end
    if (o_zero !== 1'b0) begin errors++; $display("FAIL rst_zero: got %b, required 0", o_zero); end
    if (o_ones !== 1'b0) begin errors++; $display("FAIL rst_ones: got %b, required 0", o_ones); end
    if (o_count !== 16'h0) begin errors++; $display("FAIL rst_count: got %h, required 0000", o_count); end
    if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", o_ready); end
    i_rst_n = 1'b1;
    tick();
    checks += 2;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b, required 0", o_valid); end
    if (o_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b, required 1", o_ready); end
  endtask

  task automatic test_truth_table;
    do_reset();
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(3'd0, TtA[i], TtB[i]);
    i_valid = 1'b0;
    wait_got(4);
    if (got_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i].res !== TtRes[i] || got_q[i].zero !== (i < 3) || got_q[i].ones !== (i == 3))
        begin
          errors++;
          $display("FAIL truth_table[%0d]: got res=%h z=%b o=%b, required res=%h z=%b o=%b", i,
                   got_q[i].res, got_q[i].zero, got_q[i].ones, TtRes[i], i < 3, i == 3);
        end
      end
      checks++;
      if (got_q[0].lat != S) begin
        errors++;
        $display("FAIL latency: got %0d cycles, required %0d", got_q[0].lat, S);
      end
    end
  endtask

  task automatic test_all_ops;
    do_reset();
    i_ready = 1'b1;
    for (int op = 0; op < 8; op++) send(3'(op), 8'hA5, 8'h3C);
    i_valid = 1'b0;
    wait_got(8);
    if (got_q.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i].res !== OpsRes[i] || got_q[i].cyc != got_q[0].cyc + i) begin
          errors++;
          $display("FAIL all_ops[%0d]: got %h at cycle +%0d, required %h at +%0d", i,
                   got_q[i].res, got_q[i].cyc - got_q[0].cyc, OpsRes[i], i);
        end
      end
    end
    tick();
    checks++;
    if (o_count !== 16'd8) begin
      errors++;
      $display("FAIL all_ops_count: got %0d, required 8", o_count);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] ba [3];
    logic [7:0] bb [3];
    logic [7:0] br [3];
    ba = '{8'h0F, 8'h12, 8'hAA};
    bb = '{8'hF0, 8'h34, 8'hAA};
    br = '{8'hFF, 8'h26, 8'h00};
    do_reset();
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_op = 3'd2; i_a = ba[k]; i_b = bb[k];
      @(negedge i_clk);
      checks++;
      if (o_ready !== (k < 2)) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b, required %b", k, o_ready, k < 2);
      end
      if (k < 2) tick();
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_result !== 8'hFF || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b res=%h rdy=%b, required v=1 res=ff rdy=0", c,
                 o_valid, o_result, o_ready);
      end
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, required 1", o_ready);
    end
    tick();
    i_valid = 1'b0;
    wait_got(3);
    if (got_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i].res !== br[i]) begin
          errors++;
          $display("FAIL bp_order[%0d]: got %h, required %h", i, got_q[i].res, br[i]);
        end
      end
    end
    checks++;
    if (acc != 3) begin errors++; $display("FAIL bp_accepts: got %0d, required 3", acc); end
  endtask

  task automatic test_back_to_back;
    bit took;
    do_reset();
    i_valid = 1'b1;
    i_op = 3'($urandom_range(0, 7)); i_a = 8'($urandom); i_b = 8'($urandom);
    for (int c = 0; c < 60; c++) begin
      i_ready = c[0];
      @(negedge i_clk);
      took = o_ready;
      tick();
      if (took) begin
        i_op = 3'($urandom_range(0, 7)); i_a = 8'($urandom); i_b = 8'($urandom);
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    wait_got(acc);
    tick();
    checks += 4;
    if (got_q.size() != acc) begin
      errors++; $display("FAIL b2b_balance: delivered %0d, accepted %0d", got_q.size(), acc);
    end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_leftover: got %0d outstanding, required 0", exp_q.size());
    end
    if (both_n < 20 || acc < 25) begin
      errors++; $display("FAIL b2b_rate: got both=%0d acc=%0d, required >=20 and >=25", both_n, acc);
    end
    if (o_count !== deliv_cnt) begin
      errors++; $display("FAIL b2b_count: got %0d, required %0d", o_count, deliv_cnt);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    i_ready = 1'b1;
    send(3'd5, 8'h0F, 8'h33);
    send(3'd5, 8'hF0, 8'h33);
    i_valid = 1'b0;
    wait_got(2);
    tick();
    i_ready = 1'b0;
    send(3'd1, 8'h11, 8'h22);
    send(3'd1, 8'h44, 8'h08);
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_count !== 16'd2) begin
      errors++;
      $display("FAIL mid_pre: got v=%b count=%0d, required v=1 count=2", o_valid, o_count);
    end
    #3 i_rst_n = 1'b0;
    #1;
    checks += 4;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b, required 0", o_valid); end
    if (o_result !== 8'h00) begin errors++; $display("FAIL mid_result: got %h, required 00", o_result); end
    if (o_count !== 16'h0) begin errors++; $display("FAIL mid_count: got %h, required 0000", o_count); end
    if (o_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b, required 1", o_ready); end
    exp_q.delete(); got_q.delete(); acc = 0; deliv_cnt = 16'd0;
    tick();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    send(3'd0, 8'hFF, 8'hFF);
    i_valid = 1'b0;
    wait_got(1);
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0].res !== 8'hFF || got_q[0].ones !== 1'b1 || got_q[0].zero !== 1'b0) begin
        errors++;
        $display("FAIL mid_after: got res=%h o=%b z=%b, required res=ff o=1 z=0", got_q[0].res,
                 got_q[0].ones, got_q[0].zero);
      end
    end
  endtask

  task automatic test_count_wrap;
    bit hit = 1'b0;
    do_reset();
    i_ready = 1'b1;
    i_valid = 1'b1; i_op = 3'd7; i_a = 8'h5A; i_b = 8'h00;
    for (int t = 0; t < 70000 && !hit; t++) begin
      @(negedge i_clk);
      if (o_count === 16'hFFFF) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL wrap_ffff: got %h, required ffff within 70000 cycles", o_count);
    end
    @(negedge i_clk);
    checks++;
    if (o_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero: got %h, required 0000", o_count);
    end
    @(negedge i_clk);
    checks++;
    if (o_count !== 16'h0001) begin
      errors++; $display("FAIL wrap_one: got %h, required 0001", o_count);
    end
    tick();
    i_valid = 1'b0;
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_all_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
